err_stat_engine: RTL and testbench

- Synthesizable, on-chip counterpart to the software NMED sweep.
- Generates every 8-bit operand pair and drives it to an external exact multiplier and an approximate multiplier (e.g. hlr_bm2).
- Collects both products and accumulates error statistics in hardware.
- Host software reads the final registers and computes MED = sum_abs_err/count and NMED = MED/max_exact. No division is done in RTL.

---
 rtl/err_stat_engine.sv | 138 +++++++++++++
 tb/tb_err_stat_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/err_stat_engine.sv
// Hardware error-statistics sweep: walks every W-bit operand pair through an external exact and
// approximate multiplier and accumulates count, signed/absolute error sums and maxima.
module err_stat_engine #(
  parameter int W     = 8,
  parameter int LAT   = 0,
  parameter int ACC_W = 40
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_b,
  output logic             o_op_valid,
  input  logic [2*W-1:0]   i_p_exact,
  input  logic [2*W-1:0]   i_p_approx,
  output logic             o_busy,
  output logic             o_done,
  output logic [2*W:0]     o_count,
  output logic [ACC_W-1:0] o_sum_err,
  output logic [ACC_W-1:0] o_sum_abs_err,
  output logic [2*W:0]     o_max_abs_err,
  output logic [2*W-1:0]   o_max_exact
);

  localparam int PW = 2 * W;
  localparam logic [W-1:0] OP_MAX     = '1;
  localparam logic [2:0]   DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic   start_ok, last_pair, sample_valid;
  logic [2:0] drain_cnt;

  assign start_ok  = i_start && ((state == IDLE) || (state == DONE));
  assign last_pair = o_op_valid && (o_a == OP_MAX) && (o_b == OP_MAX);

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE:  if (i_start) state_nxt = SWEEP;
      SWEEP: begin
        o_busy = 1'b1;
        if (last_pair) state_nxt = (LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        if (i_start) state_nxt = SWEEP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand counters double as the operand outputs; B is the inner loop, both hold through DRAIN.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a        <= '0;
      o_b        <= '0;
      o_op_valid <= 1'b0;
    end else if (start_ok) begin
      o_a        <= '0;
      o_b        <= '0;
      o_op_valid <= 1'b1;
    end else if (state == SWEEP) begin
      if (last_pair) begin
        o_op_valid <= 1'b0;
      end else begin
        o_b <= o_b + W'(1);
        if (o_b == OP_MAX) o_a <= o_a + W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            drain_cnt <= '0;
    else if (state == DRAIN) drain_cnt <= drain_cnt + 3'd1;
    else                     drain_cnt <= '0;
  end

  generate
    if (LAT == 0) begin : g_comb
      assign sample_valid = o_op_valid;
    end else begin : g_pipe
      logic [LAT-1:0] vpipe;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      vpipe <= '0;
        else if (start_ok) vpipe <= '0;
        else begin
          vpipe[0] <= o_op_valid;
          for (int k = 1; k < LAT; k++) vpipe[k] <= vpipe[k-1];
        end
      end
      assign sample_valid = vpipe[LAT-1];
    end
  endgenerate

  // Difference is one bit wider than the products, so it never overflows.
  logic signed [PW:0] d;
  logic        [PW:0] abs_d;
  assign d     = $signed({i_p_approx[PW-1], i_p_approx}) - $signed({i_p_exact[PW-1], i_p_exact});
  assign abs_d = d[PW] ? -d : d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count       <= '0;
      o_sum_err     <= '0;
      o_sum_abs_err <= '0;
      o_max_abs_err <= '0;
      o_max_exact   <= '0;
    end else if (start_ok) begin
      o_count       <= '0;
      o_sum_err     <= '0;
      o_sum_abs_err <= '0;
      o_max_abs_err <= '0;
      o_max_exact   <= '0;
    end else if (sample_valid) begin
      o_count       <= o_count + (PW+1)'(1);
      o_sum_err     <= o_sum_err + {{(ACC_W-PW-1){d[PW]}}, d};
      o_sum_abs_err <= o_sum_abs_err + {{(ACC_W-PW-1){1'b0}}, abs_d};
      if (abs_d > o_max_abs_err) o_max_abs_err <= abs_d;
      if ($signed(i_p_exact) > $signed(o_max_exact)) o_max_exact <= i_p_exact;
    end
  end

endmodule

// File: tb/tb_err_stat_engine.sv
// Bench for err_stat_engine at W=4: one LAT=0 and one LAT=3 instance against a behavioural
// multiplier pair and a loop-over-all-pairs statistics model.
module tb_err_stat_engine;

  localparam int TW    = 4;
  localparam int TP    = 2 * TW;
  localparam int TA    = 40;
  localparam int NPAIR = 1 << (2 * TW);
  localparam int LIMIT = 2000;

  logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start3 = 1'b0;
  logic [TW-1:0] a0, b0, a3, b3;
  logic          v0, v3, busy0, done0, busy3, done3;
  logic [TP-1:0] pe0, pa0, pe3, pa3, mx0, mx3;
  logic [TP:0]   cnt0, cnt3, mae0, mae3;
  logic [TA-1:0] se0, sae0, se3, sae3;

  int mode0 = 0, mode3 = 0, seed = 0;
  int passed = 0, total = 0;
  longint e_cnt, e_se, e_sae, e_mae, e_mx;
  logic [TP:0]   snap_cnt;
  logic [TA-1:0] snap_sae;
  logic          snap_busy;

  always #5 clk = ~clk;

  err_stat_engine #(.W(TW), .LAT(0), .ACC_W(TA)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .o_a(a0), .o_b(b0), .o_op_valid(v0),
    .i_p_exact(pe0), .i_p_approx(pa0), .o_busy(busy0), .o_done(done0), .o_count(cnt0),
    .o_sum_err(se0), .o_sum_abs_err(sae0), .o_max_abs_err(mae0), .o_max_exact(mx0));

  err_stat_engine #(.W(TW), .LAT(3), .ACC_W(TA)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .o_a(a3), .o_b(b3), .o_op_valid(v3),
    .i_p_exact(pe3), .i_p_approx(pa3), .o_busy(busy3), .o_done(done3), .o_count(cnt3),
    .o_sum_err(se3), .o_sum_abs_err(sae3), .o_max_abs_err(mae3), .o_max_exact(mx3));

  function automatic int mul(input logic [TW-1:0] ua, input logic [TW-1:0] ub);
    return int'($signed(ua)) * int'($signed(ub));
  endfunction

  // Injected error of the approximate multiplier for each operating mode.
  function automatic int err_of(input int mode, input logic [TW-1:0] ua, input logic [TW-1:0] ub,
                                input int sd);
    case (mode)
      0:       return 0;
      1:       return 1;
      2:       return ub[0] ? -1 : 1;
      3:       return (ua == 4'h8 && ub == 4'h8) ? 5 : 0;
      default: return ((int'(ua) * 7 + int'(ub) * 13 + sd) % 9) - 4;
    endcase
  endfunction

  // Outside a live pair the multipliers present junk that must never be accumulated.
  always_comb begin
    pe0 = 8'h7F;
    pa0 = 8'h80;
    if (v0) begin
      pe0 = TP'(mul(a0, b0));
      pa0 = TP'(mul(a0, b0) + err_of(mode0, a0, b0, seed));
    end
  end

  logic [TW-1:0] qa [3];
  logic [TW-1:0] qb [3];
  logic [2:0]    qv = '0;
  always @(posedge clk) begin
    qa[0] <= a3; qb[0] <= b3; qv[0] <= v3;
    for (int k = 1; k < 3; k++) begin
      qa[k] <= qa[k-1]; qb[k] <= qb[k-1]; qv[k] <= qv[k-1];
    end
  end

  always_comb begin
    pe3 = 8'h7F;
    pa3 = 8'h80;
    if (qv[2]) begin
      pe3 = TP'(mul(qa[2], qb[2]));
      pa3 = TP'(mul(qa[2], qb[2]) + err_of(mode3, qa[2], qb[2], seed));
    end
  end

  task automatic model(input int mode, input int sd);
    int ex, ap, d;
    e_cnt = 0; e_se = 0; e_sae = 0; e_mae = 0; e_mx = 0;
    for (int ua = 0; ua < (1 << TW); ua++) begin
      for (int ub = 0; ub < (1 << TW); ub++) begin
        ex = mul(TW'(ua), TW'(ub));
        ap = int'($signed(TP'(ex + err_of(mode, TW'(ua), TW'(ub), sd))));
        d  = ap - ex;
        e_cnt++;
        e_se  += d;
        e_sae += (d < 0) ? -d : d;
        if (((d < 0) ? -d : d) > e_mae) e_mae = (d < 0) ? -d : d;
        if (ex > e_mx) e_mx = ex;
      end
    end
  endtask

  // Starts a sweep and counts cycles from the start edge until done; optionally re-pulses start.
  task automatic run_sweep(input bit sel, input int pulse_at, output int cycles);
    @(negedge clk);
    if (sel) start3 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start3 = 1'b0;
    snap_cnt  = sel ? cnt3 : cnt0;
    snap_sae  = sel ? sae3 : sae0;
    snap_busy = sel ? busy3 : busy0;
    cycles = 0;
    while (!(sel ? done3 : done0) && cycles < LIMIT) begin
      if (cycles == pulse_at) begin
        if (sel) start3 = 1'b1; else start0 = 1'b1;
      end
      @(posedge clk); #1;
      start0 = 1'b0; start3 = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({a0, b0, v0, busy0, done0, cnt0, se0, sae0, mae0, mx0} !== '0) $display("FAIL reset_dut0 outputs not all zero: a=%h b=%h v=%b busy=%b done=%b cnt=%0d", a0, b0, v0, busy0, done0, cnt0);
    else passed++;
    total++;
    if ({a3, b3, v3, busy3, done3, cnt3, se3, sae3, mae3, mx3} !== '0) $display("FAIL reset_dut3 outputs not all zero: a=%h b=%h v=%b busy=%b done=%b cnt=%0d", a3, b3, v3, busy3, done3, cnt3);
    else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy0, done0, v0} !== 3'b000) $display("FAIL reset_release_idle busy/done/valid=%b expected 000", {busy0, done0, v0});
    else passed++;
  endtask

  task automatic test_sweep(input string name, input bit sel, input int mode, input int lat);
    int cyc;
    if (sel) mode3 = mode; else mode0 = mode;
    run_sweep(sel, -1, cyc);
    model(mode, seed);
    total++;
    if (cyc !== NPAIR + lat) $display("FAIL %s_done_cycle got %0d expected %0d", name, cyc, NPAIR + lat);
    else passed++;
    total++;
    if ((sel ? cnt3 : cnt0) !== (TP+1)'(e_cnt)) $display("FAIL %s_count got %0d expected %0d", name, sel ? cnt3 : cnt0, e_cnt);
    else passed++;
    total++;
    if ((sel ? se3 : se0) !== TA'(e_se)) $display("FAIL %s_sum_err got %0d expected %0d", name, $signed(sel ? se3 : se0), e_se);
    else passed++;
    total++;
    if ((sel ? sae3 : sae0) !== TA'(e_sae)) $display("FAIL %s_sum_abs_err got %0d expected %0d", name, sel ? sae3 : sae0, e_sae);
    else passed++;
    total++;
    if ((sel ? mae3 : mae0) !== (TP+1)'(e_mae)) $display("FAIL %s_max_abs_err got %0d expected %0d", name, sel ? mae3 : mae0, e_mae);
    else passed++;
    total++;
    if ((sel ? mx3 : mx0) !== TP'(e_mx)) $display("FAIL %s_max_exact got %0d expected %0d", name, $signed(sel ? mx3 : mx0), e_mx);
    else passed++;
  endtask

  task automatic test_done_hold();
    logic [TP:0] cnt_before;
    cnt_before = cnt0;
    total++;
    if ({a0, b0, v0} !== {4'hF, 4'hF, 1'b0}) $display("FAIL done_operand_hold a=%h b=%h v=%b expected f f 0", a0, b0, v0);
    else passed++;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if ({done0, busy0, cnt0} !== {1'b1, 1'b0, cnt_before}) $display("FAIL done_frozen done=%b busy=%b cnt=%0d expected 1 0 %0d", done0, busy0, cnt0, cnt_before);
    else passed++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      seed = int'($urandom_range(0, 999));
      repeat ($urandom_range(1, 20)) @(posedge clk);
      test_sweep("random_lat0", 1'b0, 4, 0);
    end
    seed = int'($urandom_range(0, 999));
    test_sweep("random_lat3", 1'b1, 4, 3);
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode0 = 1;
    run_sweep(1'b0, 100, cyc);
    total++;
    if (cyc !== NPAIR) $display("FAIL start_ignored_cycle got %0d expected %0d", cyc, NPAIR);
    else passed++;
    total++;
    if (cnt0 !== (TP+1)'(NPAIR)) $display("FAIL start_ignored_count got %0d expected %0d", cnt0, NPAIR);
    else passed++;
    mode0 = 2;
    run_sweep(1'b0, -1, cyc);
    total++;
    if ({snap_busy, snap_cnt, snap_sae} !== {1'b1, {(TP+1){1'b0}}, {TA{1'b0}}}) $display("FAIL restart_clear busy=%b cnt=%0d sae=%0d expected 1 0 0", snap_busy, snap_cnt, snap_sae);
    else passed++;
    model(2, seed);
    total++;
    if ({se0, sae0} !== {TA'(e_se), TA'(e_sae)}) $display("FAIL restart_rerun sum_err=%0d sum_abs=%0d expected %0d %0d", $signed(se0), sae0, e_se, e_sae);
    else passed++;
  endtask

  task automatic test_mid_reset();
    mode0 = 0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1; start0 = 1'b0;
    repeat (150) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a0, b0, v0, busy0, done0, cnt0, se0, sae0, mae0, mx0} !== '0) $display("FAIL mid_reset_async a=%h b=%h v=%b busy=%b cnt=%0d sae=%0d", a0, b0, v0, busy0, cnt0, sae0);
    else passed++;
    start0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy0, v0} !== 2'b00) $display("FAIL mid_reset_start_blocked busy/valid=%b expected 00", {busy0, v0});
    else passed++;
    @(negedge clk); start0 = 1'b0; rst_n = 1'b1;
    test_sweep("after_reset", 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sweep("exact", 1'b0, 0, 0);
    test_done_hold();
    test_sweep("plus_one", 1'b0, 1, 0);
    test_sweep("alternate", 1'b0, 2, 0);
    test_sweep("latency", 1'b1, 3, 3);
    test_random();
    test_start_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
